// File: rtl/gene_pkg.sv
// gene_pkg: shared types and constants for the stripe feeder and its
// neighbours (gene memories, PE_array_64).
//   base_t          2-bit nucleotide code
//   SEQ_LEN         bases per gene
//   PE_NUM          PEs per array = gene-B bases per stripe
//   SCORE_W         alignment score width
//   GAP_CYCLES      idle cycles (start low) between B update and first A base
//   feeder_state_t  stripe_feeder FSM encoding
package gene_pkg;

    localparam int SEQ_LEN     = 1024;
    localparam int PE_NUM      = 64;
    localparam int SCORE_W     = 14;
    localparam int GAP_CYCLES  = 4;
    localparam int NUM_STRIPES = SEQ_LEN / PE_NUM;
    localparam int A_ADDR_W    = 10;
    localparam int STRIPE_W    = 4;
    localparam int B_W         = 2 * PE_NUM;

    typedef logic [1:0] base_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_GAP    = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_NEXT   = 3'd5,
        ST_DONE   = 3'd6
    } feeder_state_t;

endpackage

// File: rtl/stripe_feeder.sv
// stripe_feeder: sequences PE_array_64 through a full alignment.
// For every stripe it loads 64 gene-B bases onto the array's B bus, waits
// GAP_CYCLES, then streams gene A one base per cycle with a start strobe.
// When the array reports stripe_end it records start position and score,
// keeps the running maximum and advances to the next stripe.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_go                  one-cycle start request (ignored while busy)
//   o_a_addr / i_a_data   gene-A memory, 1-cycle read latency
//   o_b_addr / i_b_data   gene-B stripe memory, 1-cycle read latency
//   o_pe_start, o_pe_A, o_pe_B                  drive the array inputs
//   i_stripe_end, i_start_position, i_max_score_stripe   array results
//   o_busy, o_done        alignment in progress / one-cycle end pulse
//   o_max_score           running (then final) maximum over stripes
//   o_stripe_idx          current stripe
//   o_dbg_state           FSM state, for observation only
//   Optional (macro STRIPE_TRACE_EN): o_trace_valid, o_trace_stripe,
//   o_trace_score, o_trace_pos -- one pulse per captured stripe.
//
// Handshake: o_pe_start high qualifies o_pe_A for exactly that cycle (no
// back-pressure). i_stripe_end is a one-cycle event; when sampled high in
// STREAM or DRAIN the strobe drops on that same edge, the prefetched base is
// dropped and i_start_position / i_max_score_stripe are taken that cycle.
module stripe_feeder
    import gene_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_go,
    output logic [A_ADDR_W-1:0]     o_a_addr,
    input  base_t                   i_a_data,
    output logic [STRIPE_W-1:0]     o_b_addr,
    input  logic [B_W-1:0]          i_b_data,
    output logic                    o_pe_start,
    output base_t                   o_pe_A,
    output logic [B_W-1:0]          o_pe_B,
    input  logic                    i_stripe_end,
    input  logic [A_ADDR_W-1:0]     i_start_position,
    input  logic [SCORE_W-1:0]      i_max_score_stripe,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [SCORE_W-1:0]      o_max_score,
    output logic [STRIPE_W-1:0]     o_stripe_idx,
    output feeder_state_t           o_dbg_state
`ifdef STRIPE_TRACE_EN
    ,
    output logic                    o_trace_valid,
    output logic [STRIPE_W-1:0]     o_trace_stripe,
    output logic [SCORE_W-1:0]      o_trace_score,
    output logic [A_ADDR_W-1:0]     o_trace_pos
`endif
);

    // One extra bit on the A pointer so "all bases issued" (== SEQ_LEN) and
    // "next stripe would start past the end" are plain compares.
    localparam int PTR_W = A_ADDR_W + 1;
    localparam logic [PTR_W-1:0]    SEQ_LEN_P   = PTR_W'(SEQ_LEN);
    localparam logic [STRIPE_W-1:0] LAST_STRIPE = STRIPE_W'(NUM_STRIPES - 1);
    localparam logic [2:0]          GAP_LAST    = 3'(GAP_CYCLES - 1);
    // The first A read is issued two cycles before the end of GAP so that
    // its data lands on o_pe_A exactly on the edge leaving GAP.
    localparam logic [2:0]          GAP_ISSUE   = 3'(GAP_CYCLES - 2);

    feeder_state_t          state_q, state_d;
    logic [STRIPE_W-1:0]    stripe_q, stripe_d;
    logic [PTR_W-1:0]       a_ptr_q, a_ptr_d;
    logic [PTR_W-1:0]       next_ptr_q, next_ptr_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   fetch_v_q, fetch_v_d;
    logic                   pe_start_q, pe_start_d;
    base_t                  pe_a_q, pe_a_d;
    logic [B_W-1:0]         pe_b_q, pe_b_d;
    logic [SCORE_W-1:0]     max_q, max_d;
    logic                   issue;
    logic                   capture;

    always_comb begin
        state_d    = state_q;
        stripe_d   = stripe_q;
        a_ptr_d    = a_ptr_q;
        next_ptr_d = next_ptr_q;
        cnt_d      = cnt_q;
        fetch_v_d  = 1'b0;
        pe_start_d = 1'b0;
        pe_a_d     = pe_a_q;
        pe_b_d     = pe_b_q;
        max_d      = max_q;
        issue      = 1'b0;
        capture    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_go) begin
                    stripe_d = '0;
                    a_ptr_d  = '0;
                    max_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                // cnt 0: address out; cnt 1: memory data present, latch it.
                if (cnt_q == 3'd0) begin
                    cnt_d = 3'd1;
                end else begin
                    pe_b_d  = i_b_data;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q >= GAP_ISSUE) begin
                    issue = 1'b1;
                end
                if (fetch_v_q) begin
                    pe_a_d     = i_a_data;
                    pe_start_d = 1'b1;
                end
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM, ST_DRAIN: begin
                // stripe_end has priority over A exhaustion.
                if (i_stripe_end) begin
                    capture = 1'b1;
                    state_d = ST_NEXT;
                end else if (state_q == ST_STREAM) begin
                    if (fetch_v_q) begin
                        pe_a_d     = i_a_data;
                        pe_start_d = 1'b1;
                        issue      = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_NEXT: begin
                if ((stripe_q == LAST_STRIPE) || (next_ptr_q >= SEQ_LEN_P)) begin
                    state_d = ST_DONE;
                end else begin
                    stripe_d = stripe_q + STRIPE_W'(1);
                    a_ptr_d  = next_ptr_q;
                    cnt_d    = '0;
                    state_d  = ST_LOAD_B;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (capture) begin
            next_ptr_d = {1'b0, i_start_position} + PTR_W'(1);
            if (i_max_score_stripe > max_q) begin
                max_d = i_max_score_stripe;
            end
        end

        // Reads stop once the last base has been requested; the pipeline
        // then runs dry and STREAM falls into DRAIN.
        if (issue && (a_ptr_q < SEQ_LEN_P)) begin
            fetch_v_d = 1'b1;
            a_ptr_d   = a_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            stripe_q   <= '0;
            a_ptr_q    <= '0;
            next_ptr_q <= '0;
            cnt_q      <= '0;
            fetch_v_q  <= 1'b0;
            pe_start_q <= 1'b0;
            pe_a_q     <= '0;
            pe_b_q     <= '0;
            max_q      <= '0;
        end else begin
            state_q    <= state_d;
            stripe_q   <= stripe_d;
            a_ptr_q    <= a_ptr_d;
            next_ptr_q <= next_ptr_d;
            cnt_q      <= cnt_d;
            fetch_v_q  <= fetch_v_d;
            pe_start_q <= pe_start_d;
            pe_a_q     <= pe_a_d;
            pe_b_q     <= pe_b_d;
            max_q      <= max_d;
        end
    end

    assign o_a_addr     = a_ptr_q[A_ADDR_W-1:0];
    assign o_b_addr     = stripe_q;
    assign o_stripe_idx = stripe_q;
    assign o_pe_start   = pe_start_q;
    assign o_pe_A       = pe_a_q;
    assign o_pe_B       = pe_b_q;
    assign o_max_score  = max_q;
    assign o_busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign o_done       = (state_q == ST_DONE);
    assign o_dbg_state  = state_q;

`ifdef STRIPE_TRACE_EN
    logic                   trace_valid_q, trace_valid_d;
    logic [STRIPE_W-1:0]    trace_stripe_q, trace_stripe_d;
    logic [SCORE_W-1:0]     trace_score_q, trace_score_d;
    logic [A_ADDR_W-1:0]    trace_pos_q, trace_pos_d;

    always_comb begin
        trace_valid_d  = 1'b0;
        trace_stripe_d = trace_stripe_q;
        trace_score_d  = trace_score_q;
        trace_pos_d    = trace_pos_q;
        if (capture) begin
            trace_valid_d  = 1'b1;
            trace_stripe_d = stripe_q;
            trace_score_d  = i_max_score_stripe;
            trace_pos_d    = i_start_position;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            trace_valid_q  <= 1'b0;
            trace_stripe_q <= '0;
            trace_score_q  <= '0;
            trace_pos_q    <= '0;
        end else begin
            trace_valid_q  <= trace_valid_d;
            trace_stripe_q <= trace_stripe_d;
            trace_score_q  <= trace_score_d;
            trace_pos_q    <= trace_pos_d;
        end
    end

    assign o_trace_valid  = trace_valid_q;
    assign o_trace_stripe = trace_stripe_q;
    assign o_trace_score  = trace_score_q;
    assign o_trace_pos    = trace_pos_q;
`endif

endmodule

// File: tb/tb_stripe_feeder.sv
`timescale 1ns/1ps
module tb_stripe_feeder;
    import gene_pkg::*;

    localparam int GAP_LEN = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                i_rst;
    logic                i_go;
    logic [9:0]          o_a_addr;
    base_t               i_a_data;
    logic [3:0]          o_b_addr;
    logic [127:0]        i_b_data;
    logic                o_pe_start;
    base_t               o_pe_A;
    logic [127:0]        o_pe_B;
    logic                i_stripe_end;
    logic [9:0]          i_start_position;
    logic [13:0]         i_max_score_stripe;
    logic                o_busy;
    logic                o_done;
    logic [13:0]         o_max_score;
    logic [3:0]          o_stripe_idx;
    feeder_state_t       o_dbg_state;
`ifdef STRIPE_TRACE_EN
    logic                o_trace_valid;
    logic [3:0]          o_trace_stripe;
    logic [13:0]         o_trace_score;
    logic [9:0]          o_trace_pos;
`endif

    stripe_feeder dut (
        .i_clk              (clk),
        .i_rst              (i_rst),
        .i_go               (i_go),
        .o_a_addr           (o_a_addr),
        .i_a_data           (i_a_data),
        .o_b_addr           (o_b_addr),
        .i_b_data           (i_b_data),
        .o_pe_start         (o_pe_start),
        .o_pe_A             (o_pe_A),
        .o_pe_B             (o_pe_B),
        .i_stripe_end       (i_stripe_end),
        .i_start_position   (i_start_position),
        .i_max_score_stripe (i_max_score_stripe),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_max_score        (o_max_score),
        .o_stripe_idx       (o_stripe_idx),
        .o_dbg_state        (o_dbg_state)
`ifdef STRIPE_TRACE_EN
        ,
        .o_trace_valid      (o_trace_valid),
        .o_trace_stripe     (o_trace_stripe),
        .o_trace_score      (o_trace_score),
        .o_trace_pos        (o_trace_pos)
`endif
    );

    // ---------------- memory contents ----------------
    function automatic logic [1:0] base_of(input int i);
        logic [31:0] h;
        h = 32'(i) * 32'h9E3779B1;
        return h[17:16] ^ h[27:26];
    endfunction

    function automatic logic [127:0] b_word(input int s);
        logic [127:0] w;
        for (int k = 0; k < 8; k++) w[16*k +: 16] = 16'(s * 4099 + k * 257 + 1);
        return w;
    endfunction

    // Gene memories with 1-cycle read latency.
    always @(posedge clk) begin
        i_a_data <= base_of(int'(o_a_addr));
        i_b_data <= b_word(int'(o_b_addr));
    end

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [13:0] exp_q[$];   // {stripe, A index} of each expected start beat
    logic [27:0] trc_q[$];   // {stripe, score, pos} of each expected capture
    int beats = 0, drain_cyc = 0, loadb_cyc = 0, done_cnt = 0;

    task automatic chk(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- array model ----------------
    int m_n[16];
    int m_pos[16];
    int m_score[16];
    int m_delay = 0;

    task automatic clear_plan();
        for (int s = 0; s < 16; s++) begin
            m_n[s] = 100000; m_pos[s] = 0; m_score[s] = 0;
        end
        m_delay = 0;
    endtask

    // Stripe s streams n bases starting at A index first; cap = array reports it.
    task automatic plan_stripe(input int s, input int first, input int n, input int pos, input int score, input bit cap);
        m_n[s] = cap ? n : 100000;
        m_pos[s] = pos;
        m_score[s] = score;
        for (int i = 0; i < n; i++) exp_q.push_back({4'(s), 10'(first + i)});
`ifdef STRIPE_TRACE_EN
        if (cap) trc_q.push_back({4'(s), 14'(score), 10'(pos)});
`endif
    endtask

    initial begin
        int bcnt;
        int wcnt;
        i_stripe_end = 1'b0;
        i_start_position = '0;
        i_max_score_stripe = '0;
        bcnt = 0;
        wcnt = -1;
        forever begin
            @(negedge clk);
            i_stripe_end = 1'b0;
            if (i_rst || !o_busy) begin
                bcnt = 0;
                wcnt = -1;
            end else begin
                if (o_pe_start) begin
                    bcnt++;
                    if (bcnt == m_n[o_stripe_idx]) wcnt = m_delay;
                end
                if (wcnt == 0) begin
                    i_stripe_end = 1'b1;
                    i_start_position = 10'(m_pos[o_stripe_idx]);
                    i_max_score_stripe = 14'(m_score[o_stripe_idx]);
                    wcnt = -1;
                    bcnt = 0;
                end else if (wcnt > 0) begin
                    wcnt--;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [13:0] e;
        int s;
        int idx;
        bit first_seen;
        bit prev_start;
        int low_run;
        first_seen = 0;
        prev_start = 0;
        low_run = 0;
        forever begin
            @(negedge clk);
            if (o_pe_start) begin
                beats++;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", {o_stripe_idx, o_a_addr}, 0);
                end else begin
                    e = exp_q.pop_front();
                    s = int'(e[13:10]);
                    idx = int'(e[9:0]);
                    chk((o_pe_A == base_of(idx)) && (o_pe_B == b_word(s)) && (o_stripe_idx == 4'(s)),
                        "beat", {o_stripe_idx, o_pe_A, o_pe_B}, {4'(s), base_of(idx), b_word(s)});
                end
                if (first_seen && !prev_start)
                    chk(low_run == GAP_LEN + 3, "stripe_gap", low_run, GAP_LEN + 3);
                first_seen = 1;
                low_run = 0;
            end else if (o_busy && first_seen) begin
                low_run++;
            end
            if (!o_busy) begin
                first_seen = 0;
                low_run = 0;
            end
            prev_start = o_pe_start;
            if (o_dbg_state == ST_DRAIN) drain_cyc++;
            if (o_dbg_state == ST_LOAD_B) loadb_cyc++;
            if (o_done) done_cnt++;
`ifdef STRIPE_TRACE_EN
            if (o_trace_valid) begin
                if (trc_q.size() == 0) chk(1'b0, "unexpected_trace", o_trace_stripe, 0);
                else begin
                    logic [27:0] t;
                    t = trc_q.pop_front();
                    chk({o_trace_stripe, o_trace_score, o_trace_pos} == t, "trace",
                        {o_trace_stripe, o_trace_score, o_trace_pos}, t);
                end
            end
`endif
        end
    end

    // ---------------- driver tasks ----------------
    int snap_done, snap_loadb, snap_drain;

    task automatic run_go();
        int n;
        snap_done = done_cnt;
        snap_loadb = loadb_cyc;
        snap_drain = drain_cyc;
        @(negedge clk);
        i_go = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        i_go = 1'b0;
        chk(o_busy == 1'b1, "busy_after_go", o_busy, 1);
        while (!o_pe_start && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk(n == GAP_LEN + 3, "first_start_latency", n, GAP_LEN + 3);
    endtask

    task automatic finish_run(input int exp_max, input int exp_idx, input int exp_loadb, input int exp_drain);
        int n;
        n = 0;
        while (o_done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(o_done === 1'b1, "done_seen", o_done, 1);
        chk(o_max_score == 14'(exp_max), "max_score", o_max_score, exp_max);
        chk(o_stripe_idx == 4'(exp_idx), "stripe_idx", o_stripe_idx, exp_idx);
        chk(o_busy == 1'b0, "busy_low_at_done", o_busy, 0);
        @(negedge clk);
        chk(!o_done && !o_busy && o_dbg_state == ST_IDLE, "done_one_pulse", {o_done, o_busy, o_dbg_state}, 0);
        chk(done_cnt - snap_done == 1, "done_count", done_cnt - snap_done, 1);
        chk(loadb_cyc - snap_loadb == exp_loadb, "load_b_cycles", loadb_cyc - snap_loadb, exp_loadb);
        chk(drain_cyc - snap_drain == exp_drain, "drain_cycles", drain_cyc - snap_drain, exp_drain);
        chk(exp_q.size() == 0, "beats_outstanding", exp_q.size(), 0);
    endtask

    function automatic logic [255:0] all_outs();
        logic [255:0] v;
        v = 256'({o_a_addr, o_b_addr, o_pe_start, o_pe_A, o_pe_B, o_busy, o_done, o_max_score, o_stripe_idx});
`ifdef STRIPE_TRACE_EN
        v = v | 256'({o_trace_valid, o_trace_stripe, o_trace_score, o_trace_pos});
`endif
        return v;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int n;
        i_rst = 1'b1;
        i_go = 1'b0;
        clear_plan();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(all_outs() == 0 && o_dbg_state == ST_IDLE, "reset_state", all_outs(), 0);
        i_rst = 1'b0;

        // Three stripes, scores 10/30/20; a stray go mid-run must be ignored.
        clear_plan();
        plan_stripe(0, 0, 41, 40, 10, 1);
        plan_stripe(1, 41, 20, 60, 30, 1);
        plan_stripe(2, 61, 10, 1023, 20, 1);
        run_go();
        n = 0;
        while (!(o_pe_start && o_stripe_idx == 4'd1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        i_go = 1'b1;
        @(negedge clk);
        i_go = 1'b0;
        finish_run(30, 2, 6, 0);

        // Unsigned max: 9000 has the top bit set and must beat 100.
        clear_plan();
        plan_stripe(0, 0, 2, 1, 9000, 1);
        plan_stripe(1, 2, 2, 1023, 100, 1);
        run_go();
        finish_run(9000, 1, 4, 0);

        // Position 1023 on stripe 0 ends the alignment; max restarts from 0.
        clear_plan();
        plan_stripe(0, 0, 5, 1023, 5, 1);
        run_go();
        finish_run(5, 0, 2, 0);

        // A exhausted with no stripe_end; array reports 3 cycles late.
        clear_plan();
        plan_stripe(0, 0, 1024, 1023, 77, 1);
        m_delay = 3;
        run_go();
        finish_run(77, 0, 2, 3);

        // All 16 stripes: the last stripe ends the run even with A remaining.
        clear_plan();
        for (int s = 0; s < 16; s++) plan_stripe(s, 2 * s, 2, 2 * s + 1, s, 1);
        run_go();
        finish_run(15, 15, 32, 0);

        // Reset in the middle of stripe 2, then a clean restart.
        clear_plan();
        plan_stripe(0, 0, 5, 4, 1, 1);
        plan_stripe(1, 5, 5, 9, 2, 1);
        plan_stripe(2, 10, 3, 0, 0, 0);
        run_go();
        n = 0;
        begin
            int cyc;
            cyc = 0;
            while (n < 3 && cyc < 500) begin
                if (o_pe_start && o_stripe_idx == 4'd2) n++;
                if (n < 3) begin
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        chk(n == 3, "reached_stripe2", n, 3);
        i_rst = 1'b1;
        @(negedge clk);
        chk(all_outs() == 0 && o_dbg_state == ST_IDLE, "mid_stream_reset", all_outs(), 0);
        i_rst = 1'b0;
        chk(exp_q.size() == 0, "beats_before_reset", exp_q.size(), 0);
        clear_plan();
        plan_stripe(0, 0, 3, 1023, 7, 1);
        run_go();
        finish_run(7, 0, 2, 0);

`ifdef STRIPE_TRACE_EN
        chk(trc_q.size() == 0, "traces_outstanding", trc_q.size(), 0);
`endif
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global guard so a stuck run still reports.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stripe_feeder.md
# stripe_feeder

Hardware sequencer driving `PE_array_64` through a full alignment, replacing bench-side stimulus. Each stripe it loads 64 bases of gene B from B memory onto the array's B bus, then streams gene A one base per cycle with a start strobe. On `stripe_end` it captures the array's start position and score and advances to the next stripe. It sits between the two gene memories and the PE array and reports the global maximum score.

## Interface
- `SEQ_LEN`, 1024, bases per gene.
- `PE_NUM`, 64, PEs per array, i.e. gene-B bases per stripe.
- `SCORE_W`, 14, score width.
- `GAP`, 4, idle cycles with start low between B update and first A base.
- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_go` in 1: one-cycle request to start an alignment; ignored while busy.
- `o_a_addr` out 10: gene-A memory address; read latency 1 cycle.
- `i_a_data` in 2: gene-A base.
- `o_b_addr` out 4: gene-B stripe word address (stripe index).
- `i_b_data` in 128: 64 packed bases, base k at bits [2k+1:2k]; read latency 1 cycle.
- `o_pe_start` out 1: to array `i_start`.
- `o_pe_A` out 2: to array `i_A`.
- `o_pe_B` out 128: to array `i_B`.
- `i_stripe_end` in 1: from array `o_stripe_end`.
- `i_start_position` in 10: from array `o_start_position`.
- `i_max_score_stripe` in SCORE_W: from array `o_max_score_stripe`.
- `o_busy` out 1: alignment in progress.
- `o_done` out 1: one-cycle pulse at alignment end.
- `o_max_score` out SCORE_W: running or final maximum over stripes.
- `o_stripe_idx` out 4: current stripe.

## Operation
- FSM states:
  - IDLE: waits for `i_go`.
  - LOAD_B: issues `o_b_addr` = stripe and latches `i_b_data` into `o_pe_B` one cycle later.
  - GAP: counts `GAP` cycles with `o_pe_start` = 0.
  - STREAM: feeds A.
  - DRAIN: all A fed; waits for `i_stripe_end`.
  - NEXT: updates the stripe index.
  - DONE: pulses `o_done`, then returns to IDLE.
- Registers cleared on `i_go`: stripe index, A index `a_ptr`, `o_max_score`.
- STREAM behaviour:
  - `o_a_addr` = `a_ptr`, incrementing every cycle.
  - Returned data is registered onto `o_pe_A` with `o_pe_start` = 1.
  - One base per cycle, no bubbles.
- `i_stripe_end` sampled high in STREAM or DRAIN:
  - `o_pe_start` drops to 0 at that edge.
  - Prefetched, unpresented base is discarded.
  - `next_ptr` = `i_start_position` + 1 is captured.
  - `o_max_score` = max(`o_max_score`, `i_max_score_stripe`), unsigned compare.
  - FSM goes to NEXT.
- NEXT:
  - Last stripe (index `SEQ_LEN`/`PE_NUM` − 1) or `next_ptr` ≥ `SEQ_LEN`: go to DONE. Remaining stripes are skipped.
  - Otherwise: stripe+1, `a_ptr` = `next_ptr`, go to LOAD_B.
- A exhausted (base `SEQ_LEN`−1 presented) without `stripe_end`: `o_pe_start` = 0 next cycle, enter DRAIN.
- `o_pe_B` changes only in LOAD_B and holds stable through GAP/STREAM/DRAIN.
- `i_go` outside IDLE is ignored.
- Reset at any point (mid-stream included):
  - FSM returns to IDLE within the same edge.
  - All outputs become 0: `o_pe_B` = 0, `o_max_score` = 0, `o_busy` = 0, `o_done` = 0, `o_pe_start` = 0, `o_pe_A` = 0, `o_a_addr` = 0, `o_b_addr` = 0, `o_stripe_idx` = 0.

## Timing
- Cycle 0: `i_go` sampled.
- Cycles 1–2: LOAD_B. Address issued at 1, `o_pe_B` valid from edge 2.
- Then `GAP` cycles of GAP.
- First `o_pe_start` = 1 at cycle `GAP`+3 with base `a_ptr`.
- Latency from `i_stripe_end` sampled to `o_pe_start` = 0: same edge.
- Between stripes, `o_pe_start` stays low for exactly `GAP`+3 cycles: NEXT 1 + LOAD_B 2 + GAP.
- `o_done` asserts one cycle after the final NEXT; `o_busy` falls on the same edge.
- `i_stripe_end` asserting in the same cycle as A exhaustion: the `stripe_end` path wins and DRAIN is skipped.

## Configuration
- `STRIPE_TRACE_EN` defined adds outputs:
  - `o_trace_valid`: 1-cycle pulse at each stripe capture.
  - `o_trace_stripe` (4 bits).
  - `o_trace_score` (SCORE_W).
  - `o_trace_pos` (10 bits, raw `i_start_position`).
  - All trace outputs reset to 0.
- Undefined: these ports and their registers are absent. All other behaviour is identical.

## Structure
- Shared package `gene_pkg`:
  - `base_t` (2-bit nucleotide).
  - `SCORE_W`, `PE_NUM`, `SEQ_LEN` constants.
  - FSM state enum `feeder_state_t`.
- Single flat module; no sub-module is warranted. The running max is an inline comparator.

## Test plan
- Single stripe, SEQ_LEN=128, B = 64 bases, array model asserting `stripe_end` after A index 40 with pos 40 and score 25:
  - 41 consecutive starts on addresses 0..40.
  - Stripe 1 begins at A index 41 after exactly `GAP`+3 low cycles.
- Stripe scores 10, 30, 20:
  - `o_max_score` = 30.
  - `o_done` pulses once; `o_busy` = 0 afterwards.
- Array never asserts `stripe_end` until 3 cycles after A exhausted:
  - Start falls after base 1023.
  - DRAIN holds.
  - Capture occurs on the late `stripe_end`.
- `i_start_position` = 1023 on stripe 0:
  - Immediate DONE.
  - `o_stripe_idx` stays 0.
  - Only one B load.
- `i_rst` pulsed mid-STREAM of stripe 2: all outputs 0 next cycle; a fresh `i_go` restarts at stripe 0, A index 0.
- `STRIPE_TRACE_EN` build: one `o_trace_valid` pulse per stripe carrying the stripe index, score and raw position.
